// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM states and the
// legacy pipeline control constants used throughout the core.
package pc_fetch_unit_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetchState_e;

  localparam logic RstEnable   = 1'b1;
  localparam logic ChipEnable  = 1'b1;
  localparam logic ChipDisable = 1'b0;
  localparam logic Branch      = 1'b1;
  localparam logic NoStop      = 1'b0;

  localparam int PC_STEP_DEFAULT = 4;

endpackage

// File: rtl/pc_redirect_mux.sv
// Priority select of the next fetch address: flush first, then a stored
// pending target, then a taken branch, otherwise the fallback address.
module pc_redirect_mux
  import pc_fetch_unit_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] flushAddr_i,
  input  logic              pendVld_i,
  input  logic [ADDR_W-1:0] pendAddr_i,
  input  logic              branch_i,
  input  logic [ADDR_W-1:0] branchAddr_i,
  input  logic [ADDR_W-1:0] seqAddr_i,
  output logic [ADDR_W-1:0] nextAddr_o
);

  always_comb begin
    nextAddr_o = seqAddr_i;
    if (flush_i) begin
      nextAddr_o = flushAddr_i;
    end else if (pendVld_i) begin
      nextAddr_o = pendAddr_i;
    end else if (branch_i == Branch) begin
      nextAddr_o = branchAddr_i;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch address generator with a wait-state tolerant req/ack handshake and a
// one-entry pending redirect register for redirects that arrive mid-fetch.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter int                ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
  parameter int                PC_STEP      = PC_STEP_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] new_pc,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_target_address_i,
  input  logic              if_ack_i,
  input  logic [ADDR_W-1:0] if_data_i,
  output logic [ADDR_W-1:0] pc,
  output logic              ce,
  output logic              if_req_o,
  output logic [ADDR_W-1:0] if_addr_o,
  output logic [ADDR_W-1:0] inst_o,
  output logic              inst_valid_o,
  output logic              stallreq_o
);

  fetchState_e state_q, state_d;
  logic [ADDR_W-1:0] fetchPc_q, fetchPc_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] inst_q, inst_d;
  logic [ADDR_W-1:0] pendAddr_q, pendAddr_d;
  logic ce_q, ce_d;
  logic instValid_q, instValid_d;
  logic pendVld_q, pendVld_d;
  logic pendFlush_q, pendFlush_d;
  logic discard_q, discard_d;

  logic holdIf;
  logic redirect;
  logic accept;
  logic dropData;
  logic [ADDR_W-1:0] seqAddr;
  logic [ADDR_W-1:0] ackAddr;
  logic [ADDR_W-1:0] holdAddr;
  logic [ADDR_W-1:0] pendWrite;
  logic unusedStall;

  assign unusedStall = &{1'b0, stall[5:1]};
  assign holdIf      = (stall[0] != NoStop);
  assign redirect    = flush | (branch_flag_i == Branch);
  assign accept      = ((state_q == REQ) || (state_q == WAIT)) && if_ack_i;
  assign dropData    = discard_q | flush;
  assign seqAddr     = fetchPc_q + ADDR_W'(PC_STEP);

  pc_redirect_mux #(.ADDR_W(ADDR_W)) u_ackMux (
    .flush_i      (flush),
    .flushAddr_i  (new_pc),
    .pendVld_i    (pendVld_q),
    .pendAddr_i   (pendAddr_q),
    .branch_i     (branch_flag_i),
    .branchAddr_i (branch_target_address_i),
    .seqAddr_i    (seqAddr),
    .nextAddr_o   (ackAddr)
  );

  pc_redirect_mux #(.ADDR_W(ADDR_W)) u_holdMux (
    .flush_i      (flush),
    .flushAddr_i  (new_pc),
    .pendVld_i    (1'b0),
    .pendAddr_i   (fetchPc_q),
    .branch_i     (branch_flag_i),
    .branchAddr_i (branch_target_address_i),
    .seqAddr_i    (fetchPc_q),
    .nextAddr_o   (holdAddr)
  );

  // A stored flush is sticky against later branches, so only it takes the pending slot.
  pc_redirect_mux #(.ADDR_W(ADDR_W)) u_pendMux (
    .flush_i      (flush),
    .flushAddr_i  (new_pc),
    .pendVld_i    (pendVld_q & pendFlush_q),
    .pendAddr_i   (pendAddr_q),
    .branch_i     (branch_flag_i),
    .branchAddr_i (branch_target_address_i),
    .seqAddr_i    (pendAddr_q),
    .nextAddr_o   (pendWrite)
  );

  always_comb begin
    state_d     = state_q;
    fetchPc_d   = fetchPc_q;
    pc_d        = pc_q;
    inst_d      = inst_q;
    pendAddr_d  = pendAddr_q;
    ce_d        = ce_q;
    instValid_d = instValid_q;
    pendVld_d   = pendVld_q;
    pendFlush_d = pendFlush_q;
    discard_d   = discard_q;
    case (state_q)
      IDLE: begin
        ce_d    = ChipEnable;
        state_d = REQ;
      end
      REQ, WAIT: begin
        if (accept) begin
          fetchPc_d   = ackAddr;
          instValid_d = ~dropData;
          if (!dropData) begin
            inst_d = if_data_i;
            pc_d   = fetchPc_q;
          end
          pendVld_d   = 1'b0;
          pendFlush_d = 1'b0;
          discard_d   = 1'b0;
          state_d     = holdIf ? HOLD : REQ;
        end else begin
          // The request is already on the bus, so a redirect must wait for its ack.
          instValid_d = 1'b0;
          state_d     = WAIT;
          if (redirect) begin
            pendAddr_d  = pendWrite;
            pendVld_d   = 1'b1;
            pendFlush_d = pendFlush_q | flush;
            discard_d   = 1'b1;
          end
        end
      end
      HOLD: begin
        if (redirect) begin
          fetchPc_d   = holdAddr;
          instValid_d = 1'b0;
        end
        if (!holdIf) begin
          state_d = REQ;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q     <= IDLE;
      fetchPc_q   <= RESET_VECTOR;
      pc_q        <= RESET_VECTOR;
      inst_q      <= '0;
      pendAddr_q  <= '0;
      ce_q        <= ChipDisable;
      instValid_q <= 1'b0;
      pendVld_q   <= 1'b0;
      pendFlush_q <= 1'b0;
      discard_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetchPc_q   <= fetchPc_d;
      pc_q        <= pc_d;
      inst_q      <= inst_d;
      pendAddr_q  <= pendAddr_d;
      ce_q        <= ce_d;
      instValid_q <= instValid_d;
      pendVld_q   <= pendVld_d;
      pendFlush_q <= pendFlush_d;
      discard_q   <= discard_d;
    end
  end

  assign pc           = pc_q;
  assign ce           = ce_q;
  assign if_req_o     = (state_q == REQ) || (state_q == WAIT);
  assign if_addr_o    = fetchPc_q;
  assign inst_o       = inst_q;
  assign inst_valid_o = instValid_q;
  assign stallreq_o   = (state_q == WAIT);

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
Parametrised successor to the single-cycle PC register. It generates the fetch address and drives an instruction-memory request/acknowledge handshake that tolerates wait states. Redirects (exception flush, branch) arriving mid-fetch are held in a one-entry pending register. It sits between CTRL/ID/EX and the instruction bus and feeds the IF/ID stage.

Parameters:
ADDR_W, 32, width of pc/addresses/instruction word
RESET_VECTOR, 32'h00000000, pc value after reset
PC_STEP, 4, sequential increment in bytes

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
stall  in  6  CTRL stall vector; only stall[0] used (1 = hold IF)
flush  in  1  exception flush, highest priority
new_pc  in  ADDR_W  exception handler entry address
branch_flag_i  in  1  branch taken from ID
branch_target_address_i  in  ADDR_W  branch target
if_ack_i  in  1  memory ack; data valid this cycle
if_data_i  in  ADDR_W  instruction word from memory
pc  out  ADDR_W  address of instruction presented on inst_o
ce  out  1  fetch enable (0 during reset)
if_req_o  out  1  memory request
if_addr_o  out  ADDR_W  memory address, stable while if_req_o && !if_ack_i
inst_o  out  ADDR_W  fetched instruction
inst_valid_o  out  1  inst_o/pc valid for IF/ID
stallreq_o  out  1  to CTRL: fetch outstanding, pipeline must wait

Behaviour:
- Reset (rst=1 at clk edge): state=IDLE, fetch_pc=RESET_VECTOR, pc=RESET_VECTOR, ce=0, if_req_o=0, inst_o=0, inst_valid_o=0, stallreq_o=0, pend_vld=0, discard=0.
- States: IDLE, REQ, WAIT, HOLD.
- IDLE: first edge with rst=0 -> ce=1, state REQ.
- REQ: if_req_o=1, if_addr_o=fetch_pc. With if_ack_i=1: capture inst_o=if_data_i, pc=fetch_pc, inst_valid_o=1 (unless discard), fetch_pc=next address; stay REQ, or go HOLD if stall[0]=1. With if_ack_i=0: go WAIT.
- WAIT: if_req_o=1, if_addr_o unchanged, stallreq_o=1. On ack: same capture as REQ; go REQ, or HOLD if stall[0]=1.
- HOLD: if_req_o=0. inst_o, pc and inst_valid_o are held. Go REQ in the cycle after stall[0]=0.
- Next-address priority, evaluated on each accepted ack: flush > pend_vld (stored target) > branch_flag_i > fetch_pc+PC_STEP. Addition wraps modulo 2^ADDR_W.
- Redirect with no fetch outstanding (REQ before issue, or HOLD): fetch_pc=target immediately; inst_valid_o=0 next cycle.
- Redirect during WAIT: store the target in pend_vld/pend_addr and set discard=1. A later flush overwrites a pending branch; a later branch does not overwrite a pending flush. On ack the data is dropped (inst_valid_o=0), fetch_pc=pend_addr, pend_vld=0, discard=0.
- Flush in any state except IDLE: inst_valid_o=0 the next cycle.
- Flush and ack in the same cycle: data dropped, fetch_pc=new_pc.
- stall[0] has no effect on if_addr_o while WAIT. An issued request is never withdrawn.
- rst in any state, including mid-WAIT: full reset values next cycle. A late ack after reset is ignored until state REQ.
- Latency: zero-wait memory gives one instruction per cycle. Ack on cycle N gives inst_valid_o on N+1.

Decomposition:
- Shared package/defines: state encodings (IDLE/REQ/WAIT/HOLD), existing RstEnable/ChipEnable/Branch/NoStop constants, PC_STEP default.
- One sub-module is natural: pc_redirect_mux, combinational priority select of flush/pending/branch/sequential. It is reused by the pending-register write path.

Test Plan:
- Reset release, ack tied 1: if_addr_o sequence 0x0,0x4,0x8; inst_valid_o=1 from the 2nd cycle; pc lags if_addr_o by one cycle.
- Ack delayed 3 cycles at 0x8: if_addr_o held at 0x8 and stallreq_o=1 for 3 cycles, then fetch 0xC.
- Branch to 0x100 during WAIT at 0x10: word from 0x10 dropped (inst_valid_o=0), next if_addr_o=0x100.
- Branch then flush(new_pc=0x180) in the same WAIT: next if_addr_o=0x180. Flush then branch: still 0x180.
- stall[0]=1 for 2 cycles after ack at 0x20: pc=0x20 and inst_o held, if_req_o=0; the fetch at 0x24 follows release.
- rst asserted mid-WAIT with ack arriving the next cycle: outputs return to reset values, the ack is ignored, and fetch restarts at RESET_VECTOR.
